// File: rtl/snoop_bus_pkg.sv
// rtl/snoop_bus_pkg.sv - shared encodings, field slices and FSM states for the snooping bus responder
package snoop_bus_pkg;

  localparam int MSG_W     = 10;
  localparam int TAG_W     = 3;
  localparam int DATA_W    = 3;
  localparam int MEM_DEPTH = 8;

  localparam int BUS_HI  = 9;
  localparam int BUS_LO  = 8;
  localparam int MEM_HI  = 7;
  localparam int MEM_LO  = 6;
  localparam int TAG_HI  = 5;
  localparam int TAG_LO  = 3;
  localparam int DATA_HI = 2;
  localparam int DATA_LO = 0;

  localparam logic [1:0] BUS_NONE    = 2'b00;
  localparam logic [1:0] BUS_RD_MISS = 2'b01;
  localparam logic [1:0] BUS_WR_MISS = 2'b10;
  localparam logic [1:0] BUS_INV     = 2'b11;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_DATA = 2'b01;
  localparam logic [1:0] MEM_WB   = 2'b10;
  localparam logic [1:0] MEM_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SNOOP,
    ST_RESP
  } state_t;

endpackage

// File: rtl/snoop_bus_memory_rr_arbiter.sv
// rtl/snoop_bus_memory_rr_arbiter.sv - round-robin pick starting one past the last granted requester
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int pos;

  // Scan from farthest to nearest so the nearest eligible requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    pos = 0;
    for (int k = N; k >= 1; k--) begin
      pos = (int'(last) + k) % N;
      if (req[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        idx      = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/snoop_bus_memory.sv
// rtl/snoop_bus_memory.sv - bus arbiter, snoop broadcaster and 8x3 main memory for the MESI CPUs
module snoop_bus_memory
  import snoop_bus_pkg::*;
#(
  parameter int NCPU      = 3,
  parameter int SNOOP_CYC = 4
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic [NCPU*MSG_W-1:0]   cpu_bus,
  input  logic [NCPU-1:0]         cpu_shared,
  output logic [NCPU-1:0]         grant,
  output logic [MSG_W-1:0]        bus_in,
  output logic                    shared_out,
  output logic                    busy,
  input  logic [TAG_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]       dbg_data
);

  localparam int IW = (NCPU > 1) ? $clog2(NCPU) : 1;
  localparam int CW = $clog2(SNOOP_CYC + 1);

  state_t             state, state_next;
  logic [IW-1:0]      idx, last, arb_idx;
  logic [NCPU-1:0]    consumed, req, arb_gnt, idx_mask;
  logic [MSG_W-1:0]   msg [NCPU];
  logic [MSG_W-1:0]   cur;
  logic               wb_hit, wb_fire, wb_we;
  logic [DATA_W-1:0]  wb_data, wb_val, resp_data;
  logic [CW-1:0]      cnt;
  logic [DATA_W-1:0]  mem [MEM_DEPTH];

  always_comb begin
    for (int i = 0; i < NCPU; i++) begin
      msg[i] = cpu_bus[i*MSG_W +: MSG_W];
      req[i] = (msg[i][BUS_HI:BUS_LO] != BUS_NONE) && !consumed[i];
    end
  end

  rr_arbiter #(.N(NCPU), .IW(IW)) u_arb (
    .req  (req),
    .last (last),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  assign idx_mask = NCPU'(1) << idx;

  // Lowest-numbered snooper with a matching write-back supplies the block.
  always_comb begin
    wb_fire = 1'b0;
    wb_val  = '0;
    for (int j = 0; j < NCPU; j++) begin
      if (!wb_fire && j != int'(idx) &&
          msg[j][MEM_HI:MEM_LO] == MEM_WB &&
          msg[j][TAG_HI:TAG_LO] == cur[TAG_HI:TAG_LO]) begin
        wb_fire = 1'b1;
        wb_val  = msg[j][DATA_HI:DATA_LO];
      end
    end
  end

  assign wb_we     = (state == ST_SNOOP) && !wb_hit && wb_fire && !clear;
  assign resp_data = wb_hit ? wb_data : (wb_we ? wb_val : mem[cur[TAG_HI:TAG_LO]]);
  assign dbg_data  = (wb_we && cur[TAG_HI:TAG_LO] == dbg_addr) ? wb_val : mem[dbg_addr];

  assign grant = (state == ST_GRANT) ? idx_mask : '0;
  assign busy  = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (|arb_gnt) state_next = ST_GRANT;
      ST_GRANT: state_next = ST_SNOOP;
      ST_SNOOP: if (cnt == CW'(SNOOP_CYC - 1))
                  state_next = (cur[BUS_HI:BUS_LO] == BUS_RD_MISS) ? ST_RESP : ST_IDLE;
      ST_RESP:  if (cnt == CW'(1)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= ST_IDLE;
      idx        <= '0;
      last       <= IW'(NCPU - 1);
      consumed   <= '0;
      cur        <= '0;
      wb_hit     <= 1'b0;
      wb_data    <= '0;
      cnt        <= '0;
      bus_in     <= '0;
      shared_out <= 1'b0;
    end else begin
      state <= state_next;
      for (int i = 0; i < NCPU; i++)
        if (msg[i][BUS_HI:BUS_LO] == BUS_NONE) consumed[i] <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus_in <= '0;
          if (|arb_gnt) idx <= arb_idx;
        end
        ST_GRANT: begin
          cur           <= msg[idx];
          consumed[idx] <= 1'b1;
          shared_out    <= 1'b0;
          wb_hit        <= 1'b0;
          last          <= idx;
          cnt           <= '0;
          bus_in        <= {msg[idx][BUS_HI:BUS_LO], MEM_NONE, msg[idx][TAG_HI:DATA_LO]};
        end
        ST_SNOOP: begin
          shared_out <= shared_out | (|(cpu_shared & ~idx_mask));
          if (wb_we) begin
            wb_hit  <= 1'b1;
            wb_data <= wb_val;
          end
          cnt <= cnt + CW'(1);
          if (state_next == ST_RESP) begin
            cnt    <= '0;
            bus_in <= {BUS_NONE, MEM_DATA, cur[TAG_HI:TAG_LO], resp_data};
          end else if (state_next == ST_IDLE) begin
            bus_in <= '0;
          end else begin
            bus_in <= {cur[BUS_HI:BUS_LO], MEM_NONE, cur[TAG_HI:DATA_LO]};
          end
        end
        ST_RESP: begin
          cnt <= cnt + CW'(1);
          if (state_next == ST_IDLE) bus_in <= '0;
        end
        default: bus_in <= '0;
      endcase
    end
  end

  // Memory survives clear; it only changes through snooper write-backs.
  always_ff @(posedge clock) begin
    if (wb_we) mem[cur[TAG_HI:TAG_LO]] <= wb_val;
  end

endmodule

// File: tb/tb_snoop_bus_memory.sv
// tb/tb_snoop_bus_memory.sv - scoreboard bench for snoop_bus_memory
module tb_snoop_bus_memory;

  localparam int NCPU = 3;
  localparam int SC   = 4;

  logic        clock = 1'b0;
  logic        clear;
  logic [29:0] cpu_bus;
  logic [2:0]  cpu_shared;
  logic [2:0]  grant;
  logic [9:0]  bus_in;
  logic        shared_out;
  logic        busy;
  logic [2:0]  dbg_addr;
  logic [2:0]  dbg_data;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_mem [8];
  logic [2:0] grant_q [$];
  logic [9:0] resp_q  [$];

  always #5 clock = ~clock;

  snoop_bus_memory #(.NCPU(NCPU), .SNOOP_CYC(SC)) dut (
    .clock      (clock),
    .clear      (clear),
    .cpu_bus    (cpu_bus),
    .cpu_shared (cpu_shared),
    .grant      (grant),
    .bus_in     (bus_in),
    .shared_out (shared_out),
    .busy       (busy),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cpu(input int i, input logic [9:0] w);
    cpu_bus[i*10 +: 10] = w;
  endtask

  function automatic logic [9:0] mk(input logic [1:0] b, input logic [1:0] m,
                                    input logic [2:0] t, input logic [2:0] d);
    return {b, m, t, d};
  endfunction

  // Grants and data responses are compared against the queues as they appear.
  always @(negedge clock) begin : mon
    logic [2:0] eg;
    logic [9:0] er;
    if (grant != 3'b000) begin
      if (grant_q.size() == 0) check("grant_unexpected", grant, 0);
      else begin
        eg = grant_q.pop_front();
        check("grant", grant, eg);
      end
    end
    if (bus_in[7:6] == 2'b01) begin
      if (resp_q.size() == 0) check("resp_unexpected", bus_in, 0);
      else begin
        er = resp_q.pop_front();
        check("resp", bus_in, er);
      end
    end
  end

  task automatic check_mem(input string tag);
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1;
      check($sformatf("%s_mem%0d", tag, a), dbg_data, exp_mem[a]);
    end
  endtask

  // Drives one request while the other CPUs hold their current snoop inputs.
  task automatic do_txn(input string tag, input int cpu, input logic [9:0] word);
    logic [2:0] tg;
    logic [2:0] d;
    bit hit;
    bit sh;
    tg  = word[5:3];
    hit = 0;
    sh  = 0;
    set_cpu(cpu, word);
    for (int j = 0; j < NCPU; j++) begin
      if (j != cpu) begin
        if (cpu_shared[j]) sh = 1;
        if (!hit && cpu_bus[j*10+6 +: 2] == 2'b10 && cpu_bus[j*10+3 +: 3] == tg) begin
          hit = 1;
          exp_mem[tg] = cpu_bus[j*10 +: 3];
        end
      end
    end
    d = exp_mem[tg];
    grant_q.push_back(3'b001 << cpu);
    if (word[9:8] == 2'b01) begin
      resp_q.push_back({2'b00, 2'b01, tg, d});
      resp_q.push_back({2'b00, 2'b01, tg, d});
    end
    step();
    check({tag, "_grant_busy"}, busy, 1);
    check({tag, "_grant_bus0"}, bus_in, 0);
    for (int s = 0; s < SC; s++) begin
      step();
      check({tag, "_snoop_bus"}, bus_in, {word[9:8], 2'b00, word[5:0]});
    end
    if (word[9:8] == 2'b01) begin
      step();
      check({tag, "_resp_busy"}, busy, 1);
      step();
    end
    step();
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_bus"}, bus_in, 0);
    check({tag, "_shared"}, shared_out, sh);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear      = 1'b1;
    cpu_bus    = '0;
    cpu_shared = '0;
    dbg_addr   = '0;
    for (int a = 0; a < 8; a++) exp_mem[a] = 3'd0;
    step();
    step();
    check("rst_grant", grant, 0);
    check("rst_bus_in", bus_in, 0);
    check("rst_shared", shared_out, 0);
    check("rst_busy", busy, 0);

    // All three request together straight out of reset: order 0,1,2, once each.
    set_cpu(0, mk(2'b11, 2'b00, 3'd0, 3'd0));
    set_cpu(1, mk(2'b11, 2'b00, 3'd1, 3'd0));
    set_cpu(2, mk(2'b11, 2'b00, 3'd2, 3'd0));
    grant_q.push_back(3'b001);
    grant_q.push_back(3'b010);
    grant_q.push_back(3'b100);
    step();
    clear = 1'b0;
    repeat (3 * (SC + 2) + 8) step();
    check("rr_all_granted", grant_q.size(), 0);
    check("rr_idle", busy, 0);
    cpu_bus = '0;
    step();

    // Load mem[3]=5 through a write-back during CPU0's write miss.
    set_cpu(1, mk(2'b00, 2'b10, 3'd3, 3'd5));
    do_txn("prep", 0, mk(2'b10, 2'b00, 3'd3, 3'd0));
    cpu_bus = '0;
    step();
    check_mem("prep");

    // CPU1 read miss on tag 3; its own shared line must not count.
    cpu_shared = 3'b010;
    do_txn("rd3", 1, mk(2'b01, 2'b00, 3'd3, 3'd2));
    repeat (4) step();
    check("rd3_no_regrant", busy, 0);
    cpu_bus    = '0;
    cpu_shared = '0;
    step();

    // CPU0 read miss on tag 1 with CPU2 sharing and writing back 6.
    cpu_shared = 3'b101;
    set_cpu(2, mk(2'b00, 2'b10, 3'd1, 3'd6));
    do_txn("rd1_wb", 0, mk(2'b01, 2'b00, 3'd1, 3'd0));
    cpu_bus    = '0;
    cpu_shared = '0;
    step();
    check_mem("rd1_wb");

    do_txn("inv4", 2, mk(2'b11, 2'b00, 3'd4, 3'd0));
    cpu_bus = '0;
    step();
    check_mem("inv4");

    // Write miss tag 2 while CPU0 writes back a different tag.
    set_cpu(0, mk(2'b00, 2'b10, 3'd5, 3'd7));
    do_txn("wm2", 1, mk(2'b10, 2'b00, 3'd2, 3'd0));
    cpu_bus = '0;
    step();
    check_mem("wm2");

    // Clear in the middle of SNOOP aborts the transaction.
    cpu_shared = 3'b010;
    set_cpu(0, mk(2'b01, 2'b00, 3'd1, 3'd0));
    grant_q.push_back(3'b001);
    step();
    step();
    step();
    check("clr_pre_shared", shared_out, 1);
    check("clr_pre_busy", busy, 1);
    clear      = 1'b1;
    cpu_bus    = '0;
    cpu_shared = '0;
    step();
    clear = 1'b0;
    check("clr_grant", grant, 0);
    check("clr_bus_in", bus_in, 0);
    check("clr_shared", shared_out, 0);
    check("clr_busy", busy, 0);
    step();
    step();
    check("clr_stays_idle", busy, 0);
    check_mem("clr");
    do_txn("after_clr", 0, mk(2'b01, 2'b00, 3'd1, 3'd0));
    cpu_bus = '0;
    step();
    step();

    check("grant_q_empty", grant_q.size(), 0);
    check("resp_q_empty", resp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
